// File: rtl/task_12_serializer_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : task_12_pkg
// Purpose  : Shared types and constants for the lane serializer.
// Revision : 1.0
// ============================================================================
package task_12_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_LANES    = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Lane index width; a single lane still needs a 1-bit index port.
  function automatic int lane_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/task_12_serializer_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : task_12_serializer_stream_if
// Purpose  : Vector-in / word-out valid-ready stream bundle.
// Revision : 1.0
// ============================================================================
interface task_12_serializer_stream_if
  import task_12_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_LANES    = DEF_N_LANES
);
  localparam int LANE_W = lane_w(N_LANES);

  logic [N_LANES-1:0][DATA_WIDTH-1:0] i_data;
  logic [N_LANES-1:0]                 i_mask;
  logic                               i_valid;
  logic                               o_ready;
  logic [DATA_WIDTH-1:0]              o_data;
  logic [LANE_W-1:0]                  o_lane;
  logic                               o_last;
  logic                               o_valid;
  logic                               i_ready;
  logic                               o_discard;

  modport slave (
    input  i_data, i_mask, i_valid, i_ready,
    output o_ready, o_data, o_lane, o_last, o_valid, o_discard
  );

  modport master (
    output i_data, i_mask, i_valid, i_ready,
    input  o_ready, o_data, o_lane, o_last, o_valid, o_discard
  );
endinterface
`default_nettype wire

// File: rtl/task_12_serializer_stream_lane_picker.sv
`default_nettype none
// ============================================================================
// Module   : task_12_lane_picker
// Purpose  : Finds the next set mask bit above an index (or the lowest one).
// Revision : 1.0
// ============================================================================
module task_12_lane_picker
  import task_12_pkg::*;
#(
  parameter  int N_LANES = DEF_N_LANES,
  localparam int LANE_W  = lane_w(N_LANES)
) (
  input  logic [N_LANES-1:0] i_mask,
  input  logic [LANE_W-1:0]  i_idx,
  input  logic               i_start,
  output logic [LANE_W-1:0]  o_idx,
  output logic               o_found
);

  // Scan downward so the lowest qualifying bit is the one that sticks.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = N_LANES - 1; k >= 0; k--) begin
      if (i_mask[k] && (i_start || (k > int'(i_idx)))) begin
        o_idx   = LANE_W'(k);
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/task_12_serializer_stream.sv
`default_nettype none
// ============================================================================
// Module   : task_12_serializer_stream
// Purpose  : Serializes a masked N-lane vector into a word stream, no bubbles.
// Revision : 1.0
// ============================================================================
module task_12_serializer_stream
  import task_12_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_LANES    = DEF_N_LANES
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  task_12_serializer_stream_if.slave s_if
);
  localparam int LANE_W = lane_w(N_LANES);

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic [N_LANES-1:0][DATA_WIDTH-1:0] r_buf;
  logic [N_LANES-1:0]                 r_mask;
  logic [DATA_WIDTH-1:0]              r_data;
  logic [LANE_W-1:0]                  r_lane;
  logic                               r_discard;

  logic [LANE_W-1:0] w_first_idx;
  logic [LANE_W-1:0] w_next_idx;
  logic              w_first_found;
  logic              w_next_found;
  logic              w_valid;
  logic              w_last;
  logic              w_xfer;
  logic              w_ready;
  logic              w_accept;
  logic              w_load;

  task_12_lane_picker #(.N_LANES(N_LANES)) u_first (
    .i_mask  (s_if.i_mask),
    .i_idx   ('0),
    .i_start (1'b1),
    .o_idx   (w_first_idx),
    .o_found (w_first_found)
  );

  task_12_lane_picker #(.N_LANES(N_LANES)) u_next (
    .i_mask  (r_mask),
    .i_idx   (r_lane),
    .i_start (1'b0),
    .o_idx   (w_next_idx),
    .o_found (w_next_found)
  );

  // The held word is last when no enabled lane remains above it.
  assign w_valid  = (r_state == ST_SEND);
  assign w_last   = w_valid && !w_next_found;
  assign w_xfer   = w_valid && s_if.i_ready;
  assign w_ready  = i_rst_n && ((r_state == ST_IDLE) || (w_xfer && w_last));
  assign w_accept = s_if.i_valid && w_ready;
  assign w_load   = w_accept && w_first_found;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (w_xfer && w_last) w_state_nxt = w_load ? ST_SEND : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A zero-mask vector is dropped; only the discard pulse records it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf     <= '0;
      r_mask    <= '0;
      r_data    <= '0;
      r_lane    <= '0;
      r_discard <= 1'b0;
    end else begin
      r_discard <= w_accept && !w_first_found;
      if (w_load) begin
        r_buf  <= s_if.i_data;
        r_mask <= s_if.i_mask;
        r_lane <= w_first_idx;
        r_data <= s_if.i_data[w_first_idx];
      end else if (w_xfer && !w_last) begin
        r_lane <= w_next_idx;
        r_data <= r_buf[w_next_idx];
      end
    end
  end

  assign s_if.o_ready   = w_ready;
  assign s_if.o_valid   = w_valid;
  assign s_if.o_data    = r_data;
  assign s_if.o_lane    = r_lane;
  assign s_if.o_last    = w_last;
  assign s_if.o_discard = r_discard;

endmodule
`default_nettype wire

// File: tb/tb_task_12_serializer_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_task_12_serializer_stream
// Purpose  : Scoreboard bench for the lane serializer (3, 8 and 1 lanes).
// Revision : 1.0
// ============================================================================
module tb_task_12_serializer_stream;
  import task_12_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          lane;
    logic        last;
  } exp_t;

  exp_t q3[$];
  exp_t q8[$];
  exp_t q1[$];
  int   stamps[$];
  int   last8 = 0, last1 = 0, nz8 = 0, nz1 = 0;
  bit   rnd_on = 1'b0;

  task_12_serializer_stream_if #(.DATA_WIDTH(32), .N_LANES(3)) if3 ();
  task_12_serializer_stream_if #(.DATA_WIDTH(8),  .N_LANES(8)) if8 ();
  task_12_serializer_stream_if #(.DATA_WIDTH(8),  .N_LANES(1)) if1 ();

  task_12_serializer_stream #(.DATA_WIDTH(32), .N_LANES(3)) u_dut (
    .i_clk (clk), .i_rst_n (rst_n), .s_if (if3.slave));
  task_12_serializer_stream #(.DATA_WIDTH(8), .N_LANES(8)) u_dut8 (
    .i_clk (clk), .i_rst_n (rst_n), .s_if (if8.slave));
  task_12_serializer_stream #(.DATA_WIDTH(8), .N_LANES(1)) u_dut1 (
    .i_clk (clk), .i_rst_n (rst_n), .s_if (if1.slave));

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitors: pop and compare whenever a word transfers.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if3.o_valid && if3.i_ready) begin
      if (q3.size() == 0) check("dut3 unexpected word", 64'(if3.o_data), 64'hDEAD);
      else begin
        e = q3.pop_front();
        check("dut3 data", 64'(if3.o_data), 64'(e.d));
        check("dut3 lane", 64'(if3.o_lane), 64'(e.lane));
        check("dut3 last", 64'(if3.o_last), 64'(e.last));
      end
      stamps.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if8.o_valid && if8.i_ready) begin
      if (if8.o_last) last8++;
      if (q8.size() == 0) check("dut8 unexpected word", 64'(if8.o_data), 64'hDEAD);
      else begin
        e = q8.pop_front();
        check("dut8 data", 64'(if8.o_data), 64'(e.d));
        check("dut8 lane", 64'(if8.o_lane), 64'(e.lane));
        check("dut8 last", 64'(if8.o_last), 64'(e.last));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if1.o_valid && if1.i_ready) begin
      if (if1.o_last) last1++;
      if (q1.size() == 0) check("dut1 unexpected word", 64'(if1.o_data), 64'hDEAD);
      else begin
        e = q1.pop_front();
        check("dut1 data", 64'(if1.o_data), 64'(e.d));
        check("dut1 lane", 64'(if1.o_lane), 64'(e.lane));
        check("dut1 last", 64'(if1.o_last), 64'(e.last));
      end
    end
  end

  // Drivers: push expected words, hold i_valid until accepted.
  task automatic send3(input logic [31:0] a, b, c, input logic [2:0] m);
    logic [31:0] v[3];
    int hi = -1;
    bit ok = 1'b0;
    v[0] = a; v[1] = b; v[2] = c;
    for (int k = 0; k < 3; k++) if (m[k]) hi = k;
    for (int k = 0; k < 3; k++) if (m[k]) q3.push_back('{v[k], k, (k == hi)});
    if3.i_data  = {c, b, a};
    if3.i_mask  = m;
    if3.i_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = if3.o_ready;
    end
    if (!ok) check("dut3 accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if3.i_valid = 1'b0;
  endtask

  task automatic send8(input logic [7:0][7:0] d, input logic [7:0] m);
    int hi = -1;
    bit ok = 1'b0;
    for (int k = 0; k < 8; k++) if (m[k]) hi = k;
    for (int k = 0; k < 8; k++) if (m[k]) q8.push_back('{32'(d[k]), k, (k == hi)});
    if (m != 0) nz8++;
    if8.i_data  = d;
    if8.i_mask  = m;
    if8.i_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = if8.o_ready;
    end
    if (!ok) check("dut8 accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if8.i_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, input logic m);
    bit ok = 1'b0;
    if (m) begin
      q1.push_back('{32'(d), 0, 1'b1});
      nz1++;
    end
    if1.i_data  = d;
    if1.i_mask  = m;
    if1.i_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = if1.o_ready;
    end
    if (!ok) check("dut1 accept timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    if1.i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = (q3.size() == 0) && (q8.size() == 0) && (q1.size() == 0) &&
             !if3.o_valid && !if8.o_valid && !if1.o_valid;
    end
    if (!done) check("drain timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    if3.i_valid = 0; if3.i_data = '0; if3.i_mask = '0; if3.i_ready = 1;
    if8.i_valid = 0; if8.i_data = '0; if8.i_mask = '0; if8.i_ready = 1;
    if1.i_valid = 0; if1.i_data = '0; if1.i_mask = '0; if1.i_ready = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset o_ready", 64'(if3.o_ready), 64'd0);
    check("reset o_valid", 64'(if3.o_valid), 64'd0);
    check("reset o_data", 64'(if3.o_data), 64'd0);
    check("reset o_lane", 64'(if3.o_lane), 64'd0);
    check("reset o_last", 64'(if3.o_last), 64'd0);
    check("reset o_discard", 64'(if3.o_discard), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle o_ready", 64'(if3.o_ready), 64'd1);
    @(posedge clk);
    #1;

    // Full mask, free-flowing output
    send3(32'hA, 32'hB, 32'hC, 3'b111);
    @(negedge clk);
    check("t1 o_ready with A", 64'(if3.o_ready), 64'd0);
    @(negedge clk);
    check("t1 o_ready with B", 64'(if3.o_ready), 64'd0);
    wait_drain();

    // Back-to-back vectors, no bubble
    stamps.delete();
    send3(32'd1, 32'd2, 32'd3, 3'b111);
    send3(32'd4, 32'd5, 32'd6, 3'b111);
    wait_drain();
    check("t2 word count", 64'(stamps.size()), 64'd6);
    if (stamps.size() == 6) check("t2 span cycles", 64'(stamps[5] - stamps[0]), 64'd5);

    // Backpressure while B is held
    send3(32'hA, 32'hB, 32'hC, 3'b111);
    @(posedge clk);
    #1;
    if3.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3 held data", 64'(if3.o_data), 64'hB);
      check("t3 held lane", 64'(if3.o_lane), 64'd1);
      check("t3 held valid", 64'(if3.o_valid), 64'd1);
      check("t3 held ready", 64'(if3.o_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    if3.i_ready = 1'b1;
    wait_drain();

    // Sparse masks and the empty mask
    send3(32'hA, 32'hB, 32'hC, 3'b101);
    wait_drain();
    send3(32'hA, 32'hB, 32'hC, 3'b100);
    wait_drain();
    send3(32'hA, 32'hB, 32'hC, 3'b000);
    @(negedge clk);
    check("t4 discard pulse", 64'(if3.o_discard), 64'd1);
    check("t4 discard valid", 64'(if3.o_valid), 64'd0);
    check("t4 discard ready", 64'(if3.o_ready), 64'd1);
    @(negedge clk);
    check("t4 discard clears", 64'(if3.o_discard), 64'd0);
    wait_drain();

    // Asynchronous reset mid-vector
    send3(32'h11, 32'h22, 32'h33, 3'b111);
    @(posedge clk);
    #1;
    check("t5 lane before reset", 64'(if3.o_lane), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async valid", 64'(if3.o_valid), 64'd0);
    check("t5 async ready", 64'(if3.o_ready), 64'd0);
    check("t5 async lane", 64'(if3.o_lane), 64'd0);
    check("t5 async data", 64'(if3.o_data), 64'd0);
    q3.delete();
    repeat (2) @(posedge clk);
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5 ready after release", 64'(if3.o_ready), 64'd1);
    @(posedge clk);
    #1;
    send3(32'd7, 32'd8, 32'd9, 3'b111);
    wait_drain();

    // Wide and single-lane instances under random backpressure
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1;
        if (rnd_on) begin
          if8.i_ready = 1'($urandom_range(0, 1));
          if1.i_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    send8({8'h87, 8'h86, 8'h85, 8'h84, 8'h83, 8'h82, 8'h81, 8'h80}, 8'h81);
    send8({8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10}, 8'h00);
    send8({8'hF7, 8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1, 8'hF0}, 8'hFF);
    for (int i = 0; i < 12; i++) begin
      logic [7:0][7:0] d;
      for (int k = 0; k < 8; k++) d[k] = 8'($urandom_range(0, 255));
      send8(d, 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 16; i++) send1(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
    rnd_on = 1'b0;
    @(posedge clk);
    #2;
    if8.i_ready = 1'b1;
    if1.i_ready = 1'b1;
    wait_drain();
    check("t6 n8 last count", 64'(last8), 64'(nz8));
    check("t6 n1 last count", 64'(last1), 64'(nz1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/task_12_serializer_stream.md
Name: task_12_serializer_stream

Overview:
Parametrised successor to the fixed 3-lane task_12 serializer. It accepts a vector of N_LANES words in one valid/ready transfer and emits the lanes one word per cycle on a valid/ready output stream. A per-vector lane mask lets lanes be skipped, and full backpressure is supported. A new vector is accepted on the same cycle the last word of the previous one leaves, so back-to-back streaming has no bubbles.

Parameters:
DATA_WIDTH, 32, width of each lane word
N_LANES, 3, lanes per input vector; any value >= 1
LANE_W, max(1,$clog2(N_LANES)), localparam, width of the lane index

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset, asynchronous, active-low
i_data  in  DATA_WIDTH x [N_LANES]  input vector; element k is lane k
i_mask  in  N_LANES  lane enable; bit k=1 means lane k is emitted
i_valid  in  1  input vector valid
o_ready  out  1  block can accept a vector this cycle
o_data  out  DATA_WIDTH  serialized word
o_lane  out  LANE_W  lane index of o_data
o_last  out  1  o_data is the last enabled lane of its vector
o_valid  out  1  output word valid
i_ready  in  1  downstream accepts o_data
o_discard  out  1  one-cycle pulse: an accepted vector had an all-zero mask

Behaviour:
- One clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: o_valid=0, o_data=0, o_lane=0, o_last=0, o_discard=0, FSM=IDLE. o_ready is forced to 0 while i_rst_n=0.
- FSM states:
  - IDLE: no vector held.
  - SEND: vector held; a word is presented on the output.
- Definitions:
  - Accept: i_valid && o_ready.
  - Output transfer: o_valid && i_ready.
- o_ready = (FSM==IDLE) || (o_valid && i_ready && o_last). This is a combinational path from i_ready and is intentional.
- On accept, register i_data into a buffer and i_mask into a pending-mask register. The first enabled lane = lowest set bit of i_mask.
  - Mask nonzero: next cycle o_valid=1, o_data=buffer[first], o_lane=first, o_last=1 iff no set mask bit above first. FSM goes to SEND.
  - Mask zero: nothing is output. o_discard pulses for 1 cycle on the cycle after accept. FSM stays or returns to IDLE. Vector is dropped.
- Latency: accept at edge T gives the first word valid after edge T+1. Vector throughput = popcount(mask) cycles when i_ready=1.
- In SEND with an output transfer and o_last=0: advance to the lowest set mask bit above the current o_lane. Update o_data, o_lane and o_last on the next edge. o_valid stays 1.
- In SEND with an output transfer and o_last=1:
  - If an accept happens in the same cycle, load the new vector as above: no bubble, and o_valid stays 1 if the new mask is nonzero.
  - Otherwise o_valid goes to 0 and FSM goes to IDLE.
- While o_valid && !i_ready: o_data, o_lane and o_last hold stable, and o_ready=0.
- i_data and i_mask are sampled only on accept. Later changes have no effect on the held vector.
- N_LANES=1: o_last=1 on every word and o_lane=0.
- Reset mid-vector: the in-flight vector is lost and outputs return to reset values immediately. After release, the next accept starts at its lowest enabled lane.
- o_data is registered. No combinational path exists from i_data to o_data.

Decomposition:
- Shared package task_12_pkg holds:
  - the state typedef (IDLE, SEND);
  - a lane-width function, max(1,$clog2(n));
  - the default DATA_WIDTH and N_LANES constants.
- One sub-module, task_12_lane_picker: combinational. Given a mask and a current index, it returns the next set bit strictly above the index, plus a found flag. With a start flag it returns the lowest set bit. The top level uses it for both first-lane and next-lane selection, and uses found=0 to produce o_last.

Test Plan:
1. DATA_WIDTH=32, N_LANES=3; after reset, accept {A,B,C}=32'hA/32'hB/32'hC, mask=3'b111, i_ready=1 -> o_data A,B,C on cycles T+1..T+3; o_lane 0,1,2; o_last only with C; o_ready=0 at T+1,T+2.
2. i_valid held high with vectors {1,2,3} then {4,5,6}, mask 111 -> six consecutive valid words 1..6 with no bubble; second accept coincides with the transfer of word 3.
3. Backpressure: i_ready=0 for 3 cycles while o_data=B -> o_data=B, o_lane=1, o_valid=1 held stable; C follows on the cycle after i_ready rises; o_ready stays 0 throughout.
4. Mask=3'b101 -> A (lane 0), then C (lane 2, o_last=1). Mask=3'b100 -> single word C with o_last=1. Mask=3'b000 -> o_discard pulse at T+1, o_valid stays 0, o_ready=1 at T+1.
5. Drive i_rst_n low asynchronously (mid-clock) while o_lane=1 -> o_valid=0 before the next edge; after release o_ready=1; new vector {7,8,9}, mask 111 -> output 7 from lane 0.
6. Parameter sweep N_LANES=1 and N_LANES=8 with DATA_WIDTH=8, random masks and random i_ready -> output sequence matches a scoreboard model in order; o_last set exactly once per nonzero-mask vector.
